// File: rtl/axi_dma_rd_if.sv
// axi_dma_rd_if: AXI4 read (AR/R) channels plus the AXI4-Stream output.
// master = DMA side (drives AR, rready, AXIS data); slave = memory + stream sink.
interface axi_dma_rd_if #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] axi_araddr;
    logic [1:0]            axi_arburst;
    logic [3:0]            axi_arcache;
    logic [3:0]            axi_arid;
    logic [7:0]            axi_arlen;
    logic [2:0]            axi_arprot;
    logic [2:0]            axi_arsize;
    logic [3:0]            axi_aruser;
    logic                  axi_arvalid;
    logic                  axi_arready;
    logic [DATA_WIDTH-1:0] axi_rdata;
    logic [1:0]            axi_rresp;
    logic                  axi_rlast;
    logic                  axi_rvalid;
    logic                  axi_rready;
    logic [DATA_WIDTH-1:0] axis_tdata;
    logic                  axis_tvalid;
    logic                  axis_tready;
    logic                  axis_tlast;

    modport master (
        output axi_araddr, axi_arburst, axi_arcache, axi_arid,
        output axi_arlen, axi_arprot, axi_arsize, axi_aruser,
        output axi_arvalid,
        input  axi_arready,
        input  axi_rdata, axi_rresp, axi_rlast, axi_rvalid,
        output axi_rready,
        output axis_tdata, axis_tvalid, axis_tlast,
        input  axis_tready
    );

    modport slave (
        input  axi_araddr, axi_arburst, axi_arcache, axi_arid,
        input  axi_arlen, axi_arprot, axi_arsize, axi_aruser,
        input  axi_arvalid,
        output axi_arready,
        output axi_rdata, axi_rresp, axi_rlast, axi_rvalid,
        input  axi_rready,
        input  axis_tdata, axis_tvalid, axis_tlast,
        output axis_tready
    );
endinterface

// File: rtl/axi_dma_rd.sv
// axi_dma_rd: AXI4 INCR read-burst master streaming a memory region to AXIS.
// Ports: axi_aclk/axi_rstb, bus (AR/R + AXIS master), start/reset/loop control, status.
module axi_dma_rd #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 32,
    parameter int BURST_LEN  = 256
) (
    input  logic                  axi_aclk,
    input  logic                  axi_rstb,
    axi_dma_rd_if.master          bus,
    input  logic                  read_start,
    input  logic                  read_reset,
    input  logic                  read_loop,
    input  logic [ADDR_WIDTH-1:0] start_address,
    input  logic [31:0]           cap_size,
    output logic [ADDR_WIDTH-1:0] current_addr,
    output logic [7:0]            run_cycles,
    output logic                  rd_err,
    output logic                  play_done
);
    localparam int BURST_BYTES = BURST_LEN * DATA_WIDTH / 8;
    localparam int BB_LOG2     = $clog2(BURST_BYTES);
    localparam int BEAT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
        ~((ADDR_WIDTH'(1) << BB_LOG2) - ADDR_WIDTH'(1));

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DRAIN} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] base;
    logic [31:0]           nbursts;
    logic [31:0]           burst_idx;
    logic [BEAT_W-1:0]     beat_cnt;
    logic [ADDR_WIDTH-1:0] araddr_q;
    logic                  arvalid_q;
    logic                  abort_q;

    logic [ADDR_WIDTH-1:0] start_aligned;
    logic [31:0]           nbursts_in;
    logic                  in_data;
    logic                  in_drain;
    logic                  rready_c;
    logic                  beat_fire;
    logic                  last_beat;
    logic                  last_burst;
    logic                  unused_ok;

    function automatic logic [ADDR_WIDTH-1:0] addr_of(
        input logic [ADDR_WIDTH-1:0] b,
        input logic [31:0]           idx
    );
        return b + (ADDR_WIDTH'(idx) << BB_LOG2);
    endfunction

    assign start_aligned = start_address & ALIGN_MASK;
    assign nbursts_in    = cap_size >> BB_LOG2;
    assign in_data       = (state == S_DATA);
    assign in_drain      = (state == S_DRAIN);
    assign last_beat     = (beat_cnt == LAST_BEAT);
    assign last_burst    = (burst_idx == nbursts - 32'd1);

    // The abort cycle itself already behaves as drain: the beat is
    // swallowed rather than forwarded.
    assign rready_c  = in_drain | (in_data & (read_reset | bus.axis_tready));
    assign beat_fire = bus.axi_rvalid & rready_c;

    assign bus.axi_rready  = rready_c;
    assign bus.axis_tvalid = in_data & ~read_reset & bus.axi_rvalid;
    assign bus.axis_tdata  = in_data ? bus.axi_rdata : '0;
    assign bus.axis_tlast  = in_data & ~read_reset & last_beat & last_burst;

    assign bus.axi_araddr  = araddr_q;
    assign bus.axi_arvalid = arvalid_q;
    assign bus.axi_arburst = 2'b01;
    assign bus.axi_arcache = 4'b0011;
    assign bus.axi_arid    = '0;
    assign bus.axi_arlen   = 8'(BURST_LEN - 1);
    assign bus.axi_arprot  = '0;
    assign bus.axi_arsize  = 3'($clog2(DATA_WIDTH / 8));
    assign bus.axi_aruser  = '0;

    assign unused_ok = &{1'b0, bus.axi_rresp[0]};

    always_ff @(posedge axi_aclk or negedge axi_rstb) begin
        if (!axi_rstb) begin
            state        <= S_IDLE;
            base         <= '0;
            nbursts      <= '0;
            burst_idx    <= '0;
            beat_cnt     <= '0;
            araddr_q     <= '0;
            arvalid_q    <= 1'b0;
            abort_q      <= 1'b0;
            current_addr <= '0;
            run_cycles   <= '0;
            rd_err       <= 1'b0;
            play_done    <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (!read_reset && read_start) begin
                        base      <= start_aligned;
                        nbursts   <= nbursts_in;
                        burst_idx <= '0;
                        beat_cnt  <= '0;
                        abort_q   <= 1'b0;
                        if (nbursts_in == '0) begin
                            play_done <= 1'b1;
                        end else begin
                            play_done <= 1'b0;
                            araddr_q  <= start_aligned;
                            arvalid_q <= 1'b1;
                            state     <= S_ADDR;
                        end
                    end
                end
                S_ADDR: begin
                    // An issued AR cannot be withdrawn; an abort waits for
                    // the handshake and then drains the burst.
                    if (bus.axi_arready) begin
                        arvalid_q <= 1'b0;
                        beat_cnt  <= '0;
                        abort_q   <= 1'b0;
                        if (abort_q || read_reset) begin
                            state <= S_DRAIN;
                        end else begin
                            current_addr <= araddr_q;
                            state        <= S_DATA;
                        end
                    end else if (read_reset) begin
                        abort_q <= 1'b1;
                    end
                end
                S_DATA: begin
                    if (beat_fire &&
                        (bus.axi_rresp[1] || (bus.axi_rlast != last_beat)))
                        rd_err <= 1'b1;
                    if (beat_fire) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (read_reset) begin
                            if (last_beat || bus.axi_rlast) begin
                                beat_cnt <= '0;
                                state    <= S_IDLE;
                            end else begin
                                state <= S_DRAIN;
                            end
                        end else if (last_beat) begin
                            beat_cnt <= '0;
                            if (!last_burst) begin
                                burst_idx <= burst_idx + 32'd1;
                                araddr_q  <= addr_of(base, burst_idx + 32'd1);
                                arvalid_q <= 1'b1;
                                state     <= S_ADDR;
                            end else begin
                                run_cycles <= run_cycles + 1'b1;
                                if (read_loop) begin
                                    burst_idx <= '0;
                                    araddr_q  <= base;
                                    arvalid_q <= 1'b1;
                                    state     <= S_ADDR;
                                end else begin
                                    play_done <= 1'b1;
                                    state     <= S_IDLE;
                                end
                            end
                        end
                    end else if (read_reset) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (beat_fire) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (bus.axi_rlast || last_beat) begin
                            beat_cnt <= '0;
                            state    <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
            if (read_reset) begin
                run_cycles   <= '0;
                current_addr <= '0;
                rd_err       <= 1'b0;
                play_done    <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_axi_dma_rd.sv
// tb_axi_dma_rd: directed bench for axi_dma_rd with a one-burst AXI slave model.
// Beat data encodes its byte address so lost/duplicated beats show up.
module tb_axi_dma_rd;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        read_start;
    logic        read_reset;
    logic        read_loop;
    logic [31:0] start_address;
    logic [31:0] cap_size;
    logic [31:0] current_addr;
    logic [7:0]  run_cycles;
    logic        rd_err;
    logic        play_done;

    axi_dma_rd_if #(.DATA_WIDTH(128), .ADDR_WIDTH(32)) bus();

    axi_dma_rd #(.DATA_WIDTH(128), .ADDR_WIDTH(32), .BURST_LEN(256)) dut (
        .axi_aclk      (clk),
        .axi_rstb      (rst_n),
        .bus           (bus),
        .read_start    (read_start),
        .read_reset    (read_reset),
        .read_loop     (read_loop),
        .start_address (start_address),
        .cap_size      (cap_size),
        .current_addr  (current_addr),
        .run_cycles    (run_cycles),
        .rd_err        (rd_err),
        .play_done     (play_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] cap;
        bit          loop;
        int          tmode;
        int          passes;
        int          e_ar;
        int          e_beats;
        int          e_tlast;
        int          e_run;
        bit          e_done;
        logic [31:0] e_cur;
    } vec_t;

    int n_chk = 0;
    int n_pass = 0;

    logic [31:0] ar_q[$];
    bit          act;
    logic [31:0] s_addr;
    int          s_beat;
    int          rlast_beat = 255;
    int          err_beat = -1;
    bit          ar_stall;
    int          tmode;
    bit          aborting;

    int n_ar, ar_bad, ar_abort, ar_idx, nb;
    int n_beats, data_bad, n_tlast, tlast_bad;
    int mirror_bad, drain_bad, drained;
    int k, pass_beats;
    logic [31:0] exp_base;

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", name, got, exp);
        else
            n_pass++;
    endtask

    task automatic clear_counts();
        n_ar = 0; ar_bad = 0; ar_abort = 0; ar_idx = 0;
        n_beats = 0; data_bad = 0; n_tlast = 0; tlast_bad = 0;
        mirror_bad = 0; drain_bad = 0; drained = 0; k = 0;
    endtask

    task automatic drive_inputs();
        if (!act && ar_q.size() > 0) begin
            s_addr = ar_q.pop_front();
            act = 1'b1;
            s_beat = 0;
        end
        bus.axi_arready = !ar_stall;
        bus.axi_rvalid  = act;
        bus.axi_rdata   = act ? {4{s_addr + 32'(s_beat) * 32'h10}} : '0;
        bus.axi_rlast   = act && (s_beat == rlast_beat);
        bus.axi_rresp   = (act && s_beat == err_beat) ? 2'b10 : 2'b00;
        bus.axis_tready = (tmode == 0) ? 1'b1 :
                          (tmode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    endtask

    // Called at negedge: drive, settle, observe handshakes that the next
    // posedge will commit, then wait for the following negedge.
    task automatic tick();
        logic [31:0]  ea;
        logic [127:0] ed;
        drive_inputs();
        #1;
        if (bus.axi_arvalid && bus.axi_arready) begin
            if (aborting) begin
                ar_abort++;
            end else begin
                ea = exp_base + ((nb > 0) ? 32'(ar_idx % nb) : 32'd0) * 32'h1000;
                if (bus.axi_araddr !== ea || bus.axi_arlen !== 8'd255) ar_bad++;
                ar_idx++;
                n_ar++;
            end
            ar_q.push_back(bus.axi_araddr);
        end
        if (bus.axi_rvalid) begin
            if (aborting) begin
                if (bus.axi_rready !== 1'b1 || bus.axis_tvalid !== 1'b0) drain_bad++;
            end else if (bus.axi_rready !== bus.axis_tready ||
                         bus.axis_tvalid !== 1'b1) begin
                mirror_bad++;
            end
        end
        if (bus.axis_tvalid === 1'b1 && bus.axis_tready === 1'b1) begin
            ed = {4{exp_base + 32'(k) * 32'h10}};
            if (bus.axis_tdata !== ed) data_bad++;
            if (bus.axis_tlast !== (k == pass_beats - 1)) tlast_bad++;
            if (bus.axis_tlast === 1'b1) n_tlast++;
            n_beats++;
            k = (k + 1 == pass_beats) ? 0 : k + 1;
        end
        if (bus.axi_rvalid && bus.axi_rready === 1'b1) begin
            if (aborting) drained++;
            s_beat++;
            if (s_beat == 256) begin
                act = 1'b0;
                s_beat = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        read_reset = 1'b1;
        tick();
        read_reset = 1'b0;
        tick();
    endtask

    task automatic start_pass(logic [31:0] a, logic [31:0] c, bit lp);
        start_address = a;
        cap_size = c;
        read_loop = lp;
        exp_base = a & 32'hFFFF_F000;
        nb = int'(c >> 12);
        pass_beats = nb * 256;
        read_start = 1'b1;
        tick();
        read_start = 1'b0;
    endtask

    task automatic wait_done();
        for (int c = 0; c < 5000 && play_done !== 1'b1; c++) tick();
    endtask

    task automatic wait_slave_idle();
        for (int c = 0; c < 2000 && (act || ar_q.size() > 0); c++) tick();
        repeat (5) tick();
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{32'h1000_0000, 32'd8192,  1'b0, 0, 1, 2, 512,  1, 1, 1'b1, 32'h1000_1000};
        vecs[1] = '{32'h1000_0000, 32'd8192,  1'b0, 1, 1, 2, 512,  1, 1, 1'b1, 32'h1000_1000};
        vecs[2] = '{32'h2000_0ABC, 32'd4196,  1'b0, 0, 1, 1, 256,  1, 1, 1'b1, 32'h2000_0000};
        vecs[3] = '{32'h3000_0000, 32'd12000, 1'b1, 0, 3, 6, 1536, 3, 3, 1'b0, 32'h3000_1000};
        vecs[4] = '{32'hFFFF_F123, 32'd8192,  1'b0, 0, 1, 2, 512,  1, 1, 1'b1, 32'h0000_0000};

        rst_n = 1'b0;
        read_start = 1'b0;
        read_reset = 1'b0;
        read_loop = 1'b0;
        start_address = '0;
        cap_size = '0;
        act = 1'b0;
        ar_stall = 1'b0;
        tmode = 0;
        aborting = 1'b0;
        exp_base = '0;
        nb = 0;
        pass_beats = 1;
        clear_counts();
        @(negedge clk);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        check("rst arvalid", 32'(bus.axi_arvalid), 32'd0);
        check("rst tvalid", 32'(bus.axis_tvalid), 32'd0);
        check("rst rready", 32'(bus.axi_rready), 32'd0);
        check("rst run_cycles", 32'(run_cycles), 32'd0);
        check("rst rd_err", 32'(rd_err), 32'd0);
        check("rst play_done", 32'(play_done), 32'd0);
        check("rst current_addr", current_addr, 32'd0);
        check("arlen", 32'(bus.axi_arlen), 32'd255);
        check("arsize", 32'(bus.axi_arsize), 32'd4);
        check("arburst", 32'(bus.axi_arburst), 32'd1);
        check("arcache", 32'(bus.axi_arcache), 32'd3);

        for (int v = 0; v < 5; v++) begin
            pulse_reset();
            clear_counts();
            tmode = vecs[v].tmode;
            start_pass(vecs[v].addr, vecs[v].cap, vecs[v].loop);
            start_address = 32'hDEAD_0000;
            cap_size = 32'd0;
            if (vecs[v].loop) begin
                for (int c = 0; c < 10000 && run_cycles != 8'(vecs[v].passes); c++)
                    tick();
                check($sformatf("v%0d run_cycles", v), 32'(run_cycles), 32'(vecs[v].e_run));
                check($sformatf("v%0d play_done", v), 32'(play_done), 32'(vecs[v].e_done));
                check($sformatf("v%0d current_addr", v), current_addr, vecs[v].e_cur);
                read_reset = 1'b1;
                aborting = 1'b1;
                tick();
                read_reset = 1'b0;
                wait_slave_idle();
                aborting = 1'b0;
                check($sformatf("v%0d run after reset", v), 32'(run_cycles), 32'd0);
                check($sformatf("v%0d addr after reset", v), current_addr, 32'd0);
                check($sformatf("v%0d drain bad", v), 32'(drain_bad), 32'd0);
            end else begin
                wait_done();
                check($sformatf("v%0d run_cycles", v), 32'(run_cycles), 32'(vecs[v].e_run));
                check($sformatf("v%0d play_done", v), 32'(play_done), 32'(vecs[v].e_done));
                check($sformatf("v%0d current_addr", v), current_addr, vecs[v].e_cur);
            end
            check($sformatf("v%0d ar count", v), 32'(n_ar), 32'(vecs[v].e_ar));
            check($sformatf("v%0d ar addr/len bad", v), 32'(ar_bad), 32'd0);
            check($sformatf("v%0d beats", v), 32'(n_beats), 32'(vecs[v].e_beats));
            check($sformatf("v%0d data bad", v), 32'(data_bad), 32'd0);
            check($sformatf("v%0d tlast count", v), 32'(n_tlast), 32'(vecs[v].e_tlast));
            check($sformatf("v%0d tlast pos bad", v), 32'(tlast_bad), 32'd0);
            check($sformatf("v%0d rready mirror bad", v), 32'(mirror_bad), 32'd0);
        end
        tmode = 0;

        // Region smaller than one burst: done next cycle, no AR.
        pulse_reset();
        clear_counts();
        start_pass(32'h1000_0000, 32'd100, 1'b0);
        check("small play_done", 32'(play_done), 32'd1);
        repeat (5) tick();
        check("small ar count", 32'(n_ar), 32'd0);
        check("small arvalid", 32'(bus.axi_arvalid), 32'd0);

        // Abort at beat 10 of a burst, sink stalled while draining.
        pulse_reset();
        clear_counts();
        start_pass(32'h1000_0000, 32'd8192, 1'b0);
        for (int c = 0; c < 1000 && n_beats < 10; c++) tick();
        check("abort beats before", 32'(n_beats), 32'd10);
        read_reset = 1'b1;
        aborting = 1'b1;
        tmode = 2;
        tick();
        read_reset = 1'b0;
        wait_slave_idle();
        check("abort drained", 32'(drained), 32'd246);
        check("abort drain bad", 32'(drain_bad), 32'd0);
        check("abort extra ar", 32'(ar_abort), 32'd0);
        check("abort arvalid", 32'(bus.axi_arvalid), 32'd0);
        check("abort play_done", 32'(play_done), 32'd0);
        aborting = 1'b0;
        tmode = 0;
        clear_counts();
        start_pass(32'h4000_0000, 32'd4096, 1'b0);
        wait_done();
        check("restart beats", 32'(n_beats), 32'd256);
        check("restart data bad", 32'(data_bad), 32'd0);
        check("restart play_done", 32'(play_done), 32'd1);
        check("restart current_addr", current_addr, 32'h4000_0000);

        // Abort while AR is stalled: AR must stay up, then burst drained.
        pulse_reset();
        clear_counts();
        ar_stall = 1'b1;
        start_pass(32'h5000_0000, 32'd8192, 1'b0);
        repeat (3) tick();
        check("stall arvalid", 32'(bus.axi_arvalid), 32'd1);
        read_reset = 1'b1;
        aborting = 1'b1;
        tick();
        read_reset = 1'b0;
        repeat (3) tick();
        check("stall arvalid held", 32'(bus.axi_arvalid), 32'd1);
        check("stall araddr held", bus.axi_araddr, 32'h5000_0000);
        ar_stall = 1'b0;
        for (int c = 0; c < 1000 && drained < 256; c++) tick();
        repeat (5) tick();
        check("stall drained", 32'(drained), 32'd256);
        check("stall abort ar", 32'(ar_abort), 32'd1);
        check("stall drain bad", 32'(drain_bad), 32'd0);
        check("stall beats fwd", 32'(n_beats), 32'd0);
        check("stall arvalid end", 32'(bus.axi_arvalid), 32'd0);
        aborting = 1'b0;

        // SLVERR on beat 5 and early rlast at beat 100.
        pulse_reset();
        clear_counts();
        err_beat = 5;
        rlast_beat = 100;
        start_pass(32'h6000_0000, 32'd4096, 1'b0);
        for (int c = 0; c < 1000 && n_beats < 3; c++) tick();
        check("err before", 32'(rd_err), 32'd0);
        wait_done();
        check("err flag", 32'(rd_err), 32'd1);
        check("err beats", 32'(n_beats), 32'd256);
        check("err data bad", 32'(data_bad), 32'd0);
        check("err play_done", 32'(play_done), 32'd1);
        err_beat = -1;
        rlast_beat = 255;
        repeat (10) tick();
        check("err sticky", 32'(rd_err), 32'd1);
        pulse_reset();
        check("err cleared", 32'(rd_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
